// File: rtl/usb_fx3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_fx3_pkg
// Description : Shared definitions for the FX3 slave-FIFO interface blocks:
//               master_mode codes, socket addresses, stream-out FSM state
//               encoding and the legal range of the FX3 read latency.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_fx3_pkg;

    // master_mode codes driven by the top-level pin mux
    localparam logic [2:0] c_mode_loopback   = 3'b000;
    localparam logic [2:0] c_mode_stream_out = 3'b001;
    localparam logic [2:0] c_mode_stream_in  = 3'b010;
    localparam logic [2:0] c_mode_partial    = 3'b011;
    localparam logic [2:0] c_mode_zlp        = 3'b100;
    localparam logic [2:0] c_mode_idle       = 3'b101;

    // FX3 socket addresses
    localparam logic [1:0] c_addr_write = 2'b00;
    localparam logic [1:0] c_addr_read  = 2'b11;

    // FX3 read latency is a fixed property of the slave-FIFO configuration
    localparam int c_rd_latency_min = 2;
    localparam int c_rd_latency_max = 3;

    // Stream-out FSM state encoding (visible on state_dbg)
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_READ  = 3'd2,
        ST_TAIL  = 3'd3,
        ST_FLUSH = 3'd4
    } so_state_t;

    function automatic bit rd_latency_legal(input int lat);
        return (lat >= c_rd_latency_min) && (lat <= c_rd_latency_max);
    endfunction

endpackage : usb_fx3_pkg
`default_nettype wire

// File: rtl/usb_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_fifo
// Description : Synchronous FIFO, DEPTH x WIDTH, with occupancy count.
//               Ports: clk, rst_n (async, active-low), push/wdata,
//               pop/rdata (show-ahead, reads 0 when empty), empty, count.
//               Push and pop in the same cycle leave count unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_do_pop;

    assign empty    = (r_count == '0);
    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop = pop && !empty;
    assign count    = r_count;
    // Data is forced to zero when empty so the stream bus is quiet at reset
    assign rdata    = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The upstream credit scheme must never push into a full FIFO
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && w_full && !w_do_pop));
        end
    end

endmodule : usb_rx_fifo
`default_nettype wire

// File: rtl/usb_stream_out.sv
`default_nettype none
// ============================================================================
// Module      : usb_stream_out
// Description : FX3 slave-FIFO reader (host -> FPGA). Drives SLCS/SLOE/SLRD
//               on socket RD_ADDR, captures DQ RD_LATENCY cycles after each
//               sampled read, buffers words in a credit-managed FIFO and
//               presents them on a valid/ready stream.
//               Ports: clk, rst_n (async, active-low), master_mode, FLAGC,
//               FLAGD, DQ in; SLCS, SLOE, SLRD, SLWR, PKTEND, A out;
//               m_data/m_valid/m_ready stream; state_dbg.
//               Optional macro USB_STREAM_OUT_COUNT_EN adds word_count, a
//               wrapping count of stream handshakes since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_stream_out
    import usb_fx3_pkg::*;
#(
    parameter int         RD_WATERMARK = 4,
    parameter int         RD_LATENCY   = 2,
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [1:0] RD_ADDR      = c_addr_read
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  master_mode,
    input  logic        FLAGC,
    input  logic        FLAGD,
    input  logic [31:0] DQ,
    output logic        SLCS,
    output logic        SLOE,
    output logic        SLRD,
    output logic        SLWR,
    output logic        PKTEND,
    output logic [1:0]  A,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [2:0]  state_dbg
`ifdef USB_STREAM_OUT_COUNT_EN
    ,
    output logic [31:0] word_count
`endif
);

    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 3;
    localparam int TAIL_INIT = (RD_WATERMARK > RD_LATENCY) ? RD_WATERMARK - RD_LATENCY : 0;
    localparam int TAIL_W    = $clog2(RD_WATERMARK + 1) + 1;

    if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
        $error("usb_stream_out: RD_LATENCY must be 2 or 3");
    end

    so_state_t                 r_state, w_state_next;
    logic                      r_slcs, r_sloe, r_slrd;
    logic                      w_slcs_next, w_sloe_next, w_slrd_next;
    logic [TAIL_W-1:0]         r_tail_cnt, w_tail_next;
    logic [1:0]                r_flush_cnt, w_flush_next;
    logic [RD_LATENCY-1:0]     r_pipe;
    logic [CNT_W-1:0]          w_inflight;
    logic                      w_credit;
    logic                      w_mode_ok;
    logic                      w_abort;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    assign w_mode_ok = (master_mode == c_mode_stream_out);
    // Leaving stream_out while busy drops everything in flight
    assign w_abort   = (r_state != ST_IDLE) && !w_mode_ok;
    assign w_push    = r_pipe[RD_LATENCY-1] && !w_abort;
    assign w_pop     = !w_empty && m_ready;

    // Outstanding reads: tokens in the pipe plus a strobe currently on the
    // pins that the FX3 has not sampled yet.
    always_comb begin
        w_inflight = CNT_W'(!r_slrd);
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_pipe[i]);
        end
    end

    // A word popped this cycle frees its slot at the same edge
    assign w_credit = (CNT_W'(w_count) + w_inflight + CNT_W'(1))
                   <= (CNT_W'(FIFO_DEPTH) + CNT_W'(w_pop));

    // Next-state and next-output logic (control pins are registered)
    always_comb begin
        w_state_next = r_state;
        w_slcs_next  = r_slcs;
        w_sloe_next  = r_sloe;
        w_slrd_next  = 1'b1;
        w_tail_next  = r_tail_cnt;
        w_flush_next = r_flush_cnt;
        case (r_state)
            ST_IDLE: begin
                w_slcs_next = 1'b1;
                w_sloe_next = 1'b1;
                if (w_mode_ok && FLAGC) begin
                    w_state_next = ST_ARM;
                    w_slcs_next  = 1'b0;
                    w_sloe_next  = 1'b0;
                end
            end
            ST_ARM: begin
                w_state_next = ST_READ;
            end
            ST_READ: begin
                if (!FLAGC) begin
                    w_state_next = ST_FLUSH;
                    w_flush_next = 2'(RD_LATENCY - 1);
                end else if (!FLAGD) begin
                    if (TAIL_INIT == 0) begin
                        w_state_next = ST_FLUSH;
                        w_flush_next = 2'(RD_LATENCY - 1);
                    end else begin
                        w_state_next = ST_TAIL;
                        w_tail_next  = TAIL_W'(TAIL_INIT);
                    end
                end else begin
                    w_slrd_next = !w_credit;
                end
            end
            ST_TAIL: begin
                if (r_tail_cnt == '0) begin
                    w_state_next = ST_FLUSH;
                    w_flush_next = 2'(RD_LATENCY - 1);
                end else if (w_credit) begin
                    w_slrd_next = 1'b0;
                    w_tail_next = r_tail_cnt - TAIL_W'(1);
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == 2'd0) begin
                    w_state_next = ST_IDLE;
                    w_slcs_next  = 1'b1;
                    w_sloe_next  = 1'b1;
                end else begin
                    w_flush_next = r_flush_cnt - 2'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_slcs_next  = 1'b1;
                w_sloe_next  = 1'b1;
            end
        endcase
        if (w_abort) begin
            w_state_next = ST_IDLE;
            w_slcs_next  = 1'b1;
            w_sloe_next  = 1'b1;
            w_slrd_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_slcs      <= 1'b1;
            r_sloe      <= 1'b1;
            r_slrd      <= 1'b1;
            r_tail_cnt  <= '0;
            r_flush_cnt <= '0;
            r_pipe      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_slcs      <= w_slcs_next;
            r_sloe      <= w_sloe_next;
            r_slrd      <= w_slrd_next;
            r_tail_cnt  <= w_tail_next;
            r_flush_cnt <= w_flush_next;
            // pipe[0] holds the read the FX3 samples at this edge
            if (w_abort) begin
                r_pipe <= '0;
            end else begin
                r_pipe <= {r_pipe[RD_LATENCY-2:0], !r_slrd};
            end
        end
    end

    usb_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (DQ),
        .pop   (w_pop),
        .rdata (m_data),
        .empty (w_empty),
        .count (w_count)
    );

    assign SLCS      = r_slcs;
    assign SLOE      = r_sloe;
    assign SLRD      = r_slrd;
    assign SLWR      = 1'b1;
    assign PKTEND    = 1'b1;
    assign A         = RD_ADDR;
    assign m_valid   = !w_empty;
    assign state_dbg = r_state;

`ifdef USB_STREAM_OUT_COUNT_EN
    logic [31:0] r_word_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count <= '0;
        end else if (w_pop) begin
            r_word_count <= r_word_count + 32'd1;
        end
    end
    assign word_count = r_word_count;
`endif

endmodule : usb_stream_out
`default_nettype wire

// File: tb/tb_usb_stream_out.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_usb_stream_out
// Description : Directed self-checking bench for usb_stream_out. Contains a
//               small FX3 model: every SLRD-low sample yields a numbered word
//               on DQ RD_LATENCY cycles later; delivered words form the
//               expected stream order. Build with USB_STREAM_OUT_COUNT_EN to
//               also check word_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_stream_out;

    localparam int c_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  master_mode;
    logic        FLAGC, FLAGD;
    logic [31:0] DQ;
    logic        SLCS, SLOE, SLRD, SLWR, PKTEND;
    logic [1:0]  A;
    logic [31:0] m_data;
    logic        m_valid, m_ready;
    logic [2:0]  state_dbg;
`ifdef USB_STREAM_OUT_COUNT_EN
    logic [31:0] word_count;
`endif

    usb_stream_out #(
        .RD_WATERMARK (4),
        .RD_LATENCY   (c_LAT),
        .FIFO_DEPTH   (16),
        .RD_ADDR      (2'b11)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .master_mode (master_mode),
        .FLAGC       (FLAGC),
        .FLAGD       (FLAGD),
        .DQ          (DQ),
        .SLCS        (SLCS),
        .SLOE        (SLOE),
        .SLRD        (SLRD),
        .SLWR        (SLWR),
        .PKTEND      (PKTEND),
        .A           (A),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .state_dbg   (state_dbg)
`ifdef USB_STREAM_OUT_COUNT_EN
        ,
        .word_count  (word_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          word_seq = 0;
    int          reads_total = 0;
    int          hs_count = 0;
    int          fd_edge = -1;
    int          tail_reads = 0;
    bit          drop = 1'b0;
    bit          sched_v [64];
    logic [31:0] sched_d [64];
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: FX3 model + stream scoreboard at the falling edge, then
    // return 1 ns after the rising edge so stimulus changes away from it.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rst_n && SLRD === 1'b0) begin
            sched_v[(cyc + c_LAT) % 64] = 1'b1;
            sched_d[(cyc + c_LAT) % 64] = 32'hA500_0000 + 32'(word_seq);
            word_seq++;
            reads_total++;
            if (fd_edge >= 0 && cyc > fd_edge) tail_reads++;
        end
        if (FLAGD === 1'b0 && fd_edge < 0) fd_edge = cyc;
        if (m_valid === 1'b1 && m_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_word", m_data, 32'hFFFF_FFFF);
            end else begin
                chk("m_data", m_data, exp_q.pop_front());
            end
        end
        if (sched_v[cyc % 64]) begin
            DQ = sched_d[cyc % 64];
            if (!drop) exp_q.push_back(DQ);
            sched_v[cyc % 64] = 1'b0;
        end else begin
            DQ = 32'hDEAD_BEEF;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (state_dbg !== 3'd0 && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idle", 32'(state_dbg), 32'd0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        m_ready = 1'b1;
        while ((exp_q.size() != 0 || m_valid !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_valid", 32'(m_valid), 32'd0);
        chk("drain_expq", 32'(exp_q.size()), 32'd0);
    endtask

    int seq0, r0, r1;

    initial begin
        master_mode = 3'b101;
        FLAGC = 1'b0;
        FLAGD = 1'b1;
        m_ready = 1'b0;
        DQ = 32'h0;
        for (int i = 0; i < 64; i++) sched_v[i] = 1'b0;

        // ---- reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_SLCS", 32'(SLCS), 32'd1);
        chk("rst_SLOE", 32'(SLOE), 32'd1);
        chk("rst_SLRD", 32'(SLRD), 32'd1);
        chk("rst_SLWR", 32'(SLWR), 32'd1);
        chk("rst_PKTEND", 32'(PKTEND), 32'd1);
        chk("rst_A", 32'(A), 32'd3);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        tick();

        // ---- burst, ready=1, FLAGD high 20 cycles then low
        reads_total = 0; hs_count = 0; fd_edge = -1; tail_reads = 0;
        master_mode = 3'b001; FLAGC = 1'b1; FLAGD = 1'b1; m_ready = 1'b1;
        repeat (20) tick();
        FLAGD = 1'b0;
        tick();
        FLAGC = 1'b0;
        wait_idle(40);
        drain(40);
        chk("burst_tail_reads", 32'(tail_reads), 32'd2);
        chk("burst_no_loss", 32'(hs_count), 32'(reads_total));
        FLAGD = 1'b1;

        // ---- backpressure: ready=0 until 16 words are buffered
        reads_total = 0; seq0 = word_seq;
        m_ready = 1'b0; FLAGC = 1'b1;
        repeat (60) tick();
        chk("bp_reads", 32'(reads_total), 32'd16);
        chk("bp_buffered", 32'(exp_q.size()), 32'd16);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_slrd_paused", 32'(SLRD), 32'd1);
        chk("bp_state", 32'(state_dbg), 32'd2);
        chk("bp_first_word", m_data, 32'hA500_0000 + 32'(seq0));

        // ---- release: pushes and pops overlap, reads must not stall
        m_ready = 1'b1;
        repeat (20) tick();
        r0 = reads_total;
        repeat (10) tick();
        chk("pushpop_no_stall", 32'(reads_total - r0), 32'd10);

        // ---- FLAGC drops in READ: straight to FLUSH for RD_LATENCY cycles
        FLAGC = 1'b0;
        tick();
        r1 = reads_total;
        chk("flagc_state", 32'(state_dbg), 32'd4);
        chk("flagc_slrd", 32'(SLRD), 32'd1);
        chk("flagc_sloe", 32'(SLOE), 32'd0);
        tick();
        chk("flush_hold", 32'(state_dbg), 32'd4);
        tick();
        chk("flush_done", 32'(state_dbg), 32'd0);
        chk("flush_sloe", 32'(SLOE), 32'd1);
        chk("flush_slcs", 32'(SLCS), 32'd1);
        chk("flush_no_reads", 32'(reads_total), 32'(r1));
        drain(40);

        // ---- mode abort with reads in flight
        m_ready = 1'b0; master_mode = 3'b001; FLAGC = 1'b1;
        repeat (8) tick();
        master_mode = 3'b000;
        drop = 1'b1;
        tick();
        chk("abort_slrd", 32'(SLRD), 32'd1);
        chk("abort_sloe", 32'(SLOE), 32'd1);
        chk("abort_slcs", 32'(SLCS), 32'd1);
        chk("abort_state", 32'(state_dbg), 32'd0);
        chk("abort_keeps_fifo", 32'(m_valid), 32'd1);
        repeat (4) tick();
        drop = 1'b0;
        drain(40);

        // ---- asynchronous reset mid-READ
        master_mode = 3'b001; FLAGC = 1'b1;
        repeat (8) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_SLCS", 32'(SLCS), 32'd1);
        chk("arst_SLOE", 32'(SLOE), 32'd1);
        chk("arst_SLRD", 32'(SLRD), 32'd1);
        chk("arst_m_valid", 32'(m_valid), 32'd0);
        chk("arst_state", 32'(state_dbg), 32'd0);
        exp_q.delete();
        for (int i = 0; i < 64; i++) sched_v[i] = 1'b0;
        master_mode = 3'b000; FLAGC = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(m_valid), 32'd0);
        hs_count = 0;

`ifdef USB_STREAM_OUT_COUNT_EN
        // ---- handshake counter
        master_mode = 3'b001; FLAGC = 1'b1; m_ready = 1'b1;
        repeat (110) tick();
        FLAGC = 1'b0;
        wait_idle(40);
        drain(40);
        chk("cnt_at_least_100", 32'(hs_count >= 100), 32'd1);
        chk("word_count", word_count, 32'(hs_count));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_usb_stream_out
`default_nettype wire

// File: doc/usb_stream_out.md
Name: usb_stream_out

Overview:
FX3 slave-FIFO reader for the master_mode_stream_out direction (host -> FPGA). It drives SLRD/SLOE on socket address 2'b11 and captures DQ after the fixed FX3 read latency. Captured words go into a credit-managed receive FIFO and are presented to the fabric on a valid/ready stream. It shares the FX3 pins with the stream-in writer; a top-level mux selects between them by master_mode.

Parameters:
RD_WATERMARK, 4, FX3 partial-flag watermark in 32-bit words configured on the thread.
RD_LATENCY, 2, clk cycles from SLRD sampled low to valid DQ; fixed at 2 or 3.
FIFO_DEPTH, 16, receive FIFO depth in words; power of two, >= 8.
RD_ADDR, 2'b11, socket address driven on A while active.

Ports:
clk  in  1  interface clock, max 100 MHz
rst_n  in  1  reset, asynchronous, active-low
master_mode  in  3  mode select; block active only at 3'b001 (stream_out)
FLAGC  in  1  FX3 thread-3 flag; 1 = data available
FLAGD  in  1  FX3 partial flag; 1 = more than RD_WATERMARK words remain
DQ  in  32  FX3 data bus
SLCS  out  1  chip select, active-low
SLOE  out  1  output enable, active-low
SLRD  out  1  read strobe, active-low
SLWR  out  1  held 1
PKTEND  out  1  held 1
A  out  2  socket address
m_data  out  32  stream data
m_valid  out  1  stream valid
m_ready  in  1  stream ready
state_dbg  out  3  current FSM state

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- All FX3 control outputs are registered.
- Reset values: SLCS=1, SLOE=1, SLRD=1, SLWR=1, PKTEND=1, A=RD_ADDR, m_valid=0, m_data=0, FIFO empty, state IDLE.
- States: IDLE(0), ARM(1), READ(2), TAIL(3), FLUSH(4).
- IDLE: SLCS=1, SLOE=1, SLRD=1. If master_mode==3'b001 and FLAGC==1, go to ARM.
- ARM: SLCS=0, SLOE=0 for 1 cycle (bus turnaround), then go to READ.
- READ: SLRD=0 in any cycle where credit holds: fifo_count + inflight + 1 <= FIFO_DEPTH. Otherwise SLRD=1 and state stays READ (pause). When FLAGD==0 is sampled, go to TAIL with tail_cnt = (RD_WATERMARK > RD_LATENCY) ? RD_WATERMARK-RD_LATENCY : 0. If tail_cnt is 0, go directly to FLUSH.
- TAIL: issue credit-gated reads; tail_cnt decrements per issued read. At 0, go to FLUSH.
- FLUSH: SLRD=1, SLOE=0 held for RD_LATENCY cycles to capture in-flight words, then SLOE=1 and go to IDLE.
- Capture pipeline: an RD_LATENCY-deep shift register of read tokens. Each issued read (SLRD low) shifts in a 1. A token arriving at the tail pushes DQ into the FIFO. inflight = popcount of the token pipe.
- Credit guarantees the FIFO never overflows; overflow is an assertion failure.
- Output stream: m_valid = FIFO non-empty. Pop on m_valid && m_ready. m_data is stable while valid && !ready. FIFO push and pop in the same cycle leave count unchanged.
- master_mode leaves 3'b001 mid-operation: next cycle SLRD=1, SLOE=1, SLCS=1, token pipe cleared (in-flight words dropped), state IDLE. FIFO contents are kept and still drain.
- FLAGC==0 while in READ: treated as empty. Go to FLUSH without issuing further reads.
- Async reset mid-burst: all state cleared immediately, FIFO contents lost.

Optional Feature:
USB_STREAM_OUT_COUNT_EN.
- Defined: adds output word_count[31:0]. Increments on each m_valid && m_ready handshake, wraps at 2^32, cleared only by reset.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Package usb_fx3_pkg: master_mode codes (loopback 000 … idle 101), socket addresses (write 2'b00, read 2'b11), stream-out state encoding, RD_LATENCY legal values.
- Sub-module usb_rx_fifo: synchronous FIFO, FIFO_DEPTH x 32, exposing count, push, pop, empty.

Test Plan:
- Burst with ready=1: FLAGC=1, FLAGD high for 20 cycles then low, RD_WATERMARK=4, RD_LATENCY=2 -> 2 tail reads after FLAGD drop. Every word with SLRD low appears in order on m_data, no loss or duplicate.
- Backpressure: m_ready=0 throughout with FLAGD=1 -> SLRD pauses once fifo_count+inflight reaches 16. Exactly 16 words buffered, m_valid=1, m_data is the first word.
- Simultaneous push/pop: FIFO at 15, ready=1 while a captured word lands -> count stays 15 and no read stall occurs.
- Mode abort: master_mode switched to 3'b000 with 2 reads in flight -> next cycle SLRD=1, SLOE=1, state_dbg=0. Those 2 words are not pushed; earlier FIFO words still drain.
- Reset mid-READ: rst_n low asynchronously -> SLCS/SLOE/SLRD=1 and m_valid=0 before the next clk edge.
- COUNT_EN build: 100 handshakes -> word_count=100.
